// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the AXI read arbiter and its round-robin picker:
// FSM encodings, AXI burst/response constants and a clog2 helper.
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after i_last,
// wrapping around. Shared between the read and write arbiters.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Scan from i_last+1 upward; the first hit wins, so i_last itself is last.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!o_any && i_req[(int'(i_last) + k) % N]) begin
        o_any                          = 1'b1;
        o_idx                          = IDX_W'((int'(i_last) + k) % N);
        o_gnt[(int'(i_last) + k) % N]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// AXI4 read-port arbiter: NUM_MASTER requesters share one AR/R channel pair,
// one burst in flight, round-robin grant, sticky burst-length mismatch flag.
// Optional per-master grant counters are built when AXI_RD_ARB_STAT_EN is
// defined; otherwise stat_grant_cnt reads as zero.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int NUM_MASTER        = 4,
  parameter int AXI_ID_BITWIDTH   = 4,
  parameter int AXI_ADDR_BITWIDTH = 30,
  parameter int AXI_LEN_BITWIDTH  = 8,
  parameter int AXI_DATA_BITWIDTH = 64,
  parameter int AXI_RESP_BITWIDTH = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_MASTER-1:0]                   req_valid,
  output logic [NUM_MASTER-1:0]                   req_ready,
  input  logic [NUM_MASTER*AXI_ADDR_BITWIDTH-1:0] req_addr,
  input  logic [NUM_MASTER*AXI_LEN_BITWIDTH-1:0]  req_len,
  output logic [NUM_MASTER-1:0]                   rsp_valid,
  input  logic [NUM_MASTER-1:0]                   rsp_ready,
  output logic [AXI_DATA_BITWIDTH-1:0]            rsp_data,
  output logic [AXI_RESP_BITWIDTH-1:0]            rsp_resp,
  output logic                                    rsp_last,
  output logic                                    len_err,
  output logic [NUM_MASTER*32-1:0]                stat_grant_cnt,
  output logic [AXI_ID_BITWIDTH-1:0]              m_axi_arid,
  output logic [AXI_ADDR_BITWIDTH-1:0]            m_axi_araddr,
  output logic [AXI_LEN_BITWIDTH-1:0]             m_axi_arlen,
  output logic [2:0]                              m_axi_arsize,
  output logic [1:0]                              m_axi_arburst,
  output logic                                    m_axi_arvalid,
  input  logic                                    m_axi_arready,
  input  logic [AXI_DATA_BITWIDTH-1:0]            m_axi_rdata,
  input  logic [AXI_RESP_BITWIDTH-1:0]            m_axi_rresp,
  input  logic                                    m_axi_rlast,
  input  logic                                    m_axi_rvalid,
  output logic                                    m_axi_rready
);

  localparam int IDX_W = clog2(NUM_MASTER);
  localparam int LEN_W = AXI_LEN_BITWIDTH;

  state_t                         r_state, w_state_nxt;
  logic [IDX_W-1:0]               r_grant, r_last_grant, w_pick_idx;
  logic [NUM_MASTER-1:0]          w_pick_gnt;
  logic                           w_pick_any;
  logic [AXI_ADDR_BITWIDTH-1:0]   r_addr, w_sel_addr;
  logic [LEN_W-1:0]               r_len, w_sel_len;
  // One extra bit so an overlong burst is still distinguishable from len.
  logic [LEN_W:0]                 r_beat_cnt;
  logic                           r_len_err;
  logic                           w_req_hs, w_beat_hs;

  rr_arbiter #(.N(NUM_MASTER), .IDX_W(IDX_W)) u_rr (
    .i_req  (req_valid),
    .i_last (r_last_grant),
    .o_gnt  (w_pick_gnt),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  assign w_sel_addr = req_addr[int'(w_pick_idx)*AXI_ADDR_BITWIDTH +: AXI_ADDR_BITWIDTH];
  assign w_sel_len  = req_len[int'(w_pick_idx)*LEN_W +: LEN_W];
  assign w_req_hs   = (r_state == ST_IDLE) && w_pick_any;
  assign w_beat_hs  = (r_state == ST_DATA) && m_axi_rvalid && m_axi_rready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and handshake outputs; R channel is steered to the grantee.
  always_comb begin
    w_state_nxt   = r_state;
    req_ready     = '0;
    rsp_valid     = '0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = w_pick_gnt;
        if (w_pick_any) w_state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        rsp_valid[r_grant] = m_axi_rvalid;
        m_axi_rready       = rsp_ready[r_grant];
        if (m_axi_rvalid && rsp_ready[r_grant] && m_axi_rlast) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch the accepted request, count beats, check length on rlast.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant      <= '0;
      r_last_grant <= IDX_W'(NUM_MASTER - 1);
      r_addr       <= '0;
      r_len        <= '0;
      r_beat_cnt   <= '0;
      r_len_err    <= 1'b0;
    end else begin
      if (w_req_hs) begin
        r_grant    <= w_pick_idx;
        r_addr     <= w_sel_addr;
        r_len      <= w_sel_len;
        r_beat_cnt <= '0;
      end
      if (w_beat_hs) begin
        if (r_beat_cnt != '1) r_beat_cnt <= r_beat_cnt + {{LEN_W{1'b0}}, 1'b1};
        if (m_axi_rlast) begin
          if (r_beat_cnt != {1'b0, r_len}) r_len_err <= 1'b1;
          r_last_grant <= r_grant;
        end
      end
    end
  end

  assign m_axi_arid    = AXI_ID_BITWIDTH'(r_grant);
  assign m_axi_araddr  = r_addr;
  assign m_axi_arlen   = r_len;
  assign m_axi_arsize  = 3'(clog2(AXI_DATA_BITWIDTH / 8));
  assign m_axi_arburst = BURST_INCR;
  assign rsp_data      = m_axi_rdata;
  assign rsp_resp      = m_axi_rresp;
  assign rsp_last      = m_axi_rlast;
  assign len_err       = r_len_err;

`ifdef AXI_RD_ARB_STAT_EN
  logic [NUM_MASTER-1:0][31:0] r_stat;

  // Saturating count of accepted requests per master.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat <= '0;
    end else begin
      for (int i = 0; i < NUM_MASTER; i++) begin
        if (req_valid[i] && req_ready[i] && (r_stat[i] != 32'hFFFF_FFFF))
          r_stat[i] <= r_stat[i] + 32'd1;
      end
    end
  end

  assign stat_grant_cnt = r_stat;
`else
  assign stat_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: queued requesters, a randomised AXI
// read slave, a beat/AR monitor, and a round-robin reference model.
module tb_axi_rd_arbiter;

  localparam int NM = 4;
  localparam int AW = 30;
  localparam int LW = 8;
  localparam int DW = 64;

  typedef struct {logic [AW-1:0] addr; logic [LW-1:0] len; int beats;} burst_t;
  typedef struct {logic [DW-1:0] data; logic [1:0] resp; logic last;} beat_t;
  typedef struct {int id; logic [AW-1:0] addr; logic [LW-1:0] len; logic [2:0] size; logic [1:0] burst;} ar_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NM-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NM*AW-1:0] req_addr;
  logic [NM*LW-1:0] req_len;
  logic [DW-1:0]    rsp_data, m_axi_rdata;
  logic [1:0]       rsp_resp, m_axi_rresp, m_axi_arburst;
  logic             rsp_last, len_err;
  logic [NM*32-1:0] stat_grant_cnt;
  logic [3:0]       m_axi_arid;
  logic [AW-1:0]    m_axi_araddr;
  logic [LW-1:0]    m_axi_arlen;
  logic [2:0]       m_axi_arsize;
  logic             m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;

  axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .rsp_last(rsp_last), .len_err(len_err), .stat_grant_cnt(stat_grant_cnt),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int checks = 0;
  int failures = 0;

  burst_t req_q[NM][$];
  burst_t exp_b[NM][$];
  beat_t  rx_q[NM][$];
  ar_t    ar_q[$];
  ar_t    exp_ar[$];

  // stimulus controls
  int          slv_ar_delay = 0;
  int          slv_extra = 0;
  bit          slv_rand = 1'b0;
  bit          rdy_rand = 1'b0;
  logic [NM-1:0] hold = '0;

  // monitor observations
  int cyc = 0, acc_cyc = -1, arv_cyc = -1, rlast_cyc = -1, lerr_cyc = -1;
  int ar_stall = 0, ar_unstable = 0, bad_valid = 0;
  logic prev_arv = 1'b0, prev_stall = 1'b0, prev_lerr = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [LW-1:0] prev_len;
  logic [3:0]    prev_id;

  // Requesters: present the head of each queue; rsp_ready per control flags.
  initial begin
    req_valid = '0; req_addr = '0; req_len = '0; rsp_ready = '1;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NM; i++) begin
        if (req_q[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_addr[i*AW +: AW] = req_q[i][0].addr;
          req_len[i*LW +: LW]  = req_q[i][0].len;
        end else begin
          req_valid[i] = 1'b0;
        end
        rsp_ready[i] = hold[i] ? 1'b0 : (rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
      end
    end
  end

  // AXI read slave: data word = {00, araddr, beat index}, resp = beat ^ addr[3:2].
  initial begin
    logic ar_hs, r_hs, s_active;
    logic [AW-1:0] s_addr;
    int s_total, s_beat, s_wait;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0;
    s_active = 1'b0; s_addr = '0; s_total = 0; s_beat = 0; s_wait = 0;
    forever begin
      @(negedge clk);
      ar_hs = !rst && m_axi_arvalid && m_axi_arready;
      r_hs  = !rst && m_axi_rvalid && m_axi_rready;
      if (ar_hs) begin
        s_addr  = m_axi_araddr;
        s_total = int'(m_axi_arlen) + 1 + slv_extra;
      end
      @(posedge clk); #1;
      if (rst) begin
        s_active = 1'b0; s_wait = 0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
      end else begin
        if (ar_hs) begin s_active = 1'b1; s_beat = 0; end
        if (r_hs) begin
          s_beat++;
          if (s_beat >= s_total) s_active = 1'b0;
        end
        if (m_axi_arvalid && !s_active) begin
          if (s_wait < slv_ar_delay) begin m_axi_arready = 1'b0; s_wait++; end
          else m_axi_arready = 1'b1;
        end else begin
          m_axi_arready = 1'b0; s_wait = 0;
        end
        if (!(m_axi_rvalid && !r_hs)) begin
          if (s_active && (!slv_rand || $urandom_range(0, 2) != 0)) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = {2'b00, s_addr, 32'(s_beat)};
            m_axi_rresp  = 2'(s_beat) ^ s_addr[3:2];
            m_axi_rlast  = (s_beat == s_total - 1);
          end else begin
            m_axi_rvalid = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: record request accepts, AR handshakes and delivered beats.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        for (int i = 0; i < NM; i++)
          if (req_valid[i] && req_ready[i]) begin
            if (req_q[i].size() > 0) void'(req_q[i].pop_front());
            acc_cyc = cyc;
          end
        if (m_axi_arvalid && !prev_arv) arv_cyc = cyc;
        if (m_axi_arvalid && !m_axi_arready) begin
          ar_stall++;
          if (prev_stall && (m_axi_araddr !== prev_addr || m_axi_arlen !== prev_len || m_axi_arid !== prev_id))
            ar_unstable++;
        end
        if (m_axi_arvalid && m_axi_arready)
          ar_q.push_back('{int'(m_axi_arid), m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst});
        if ($countones(rsp_valid) > 1 || (rsp_valid != '0 && !m_axi_rvalid)) bad_valid++;
        for (int i = 0; i < NM; i++)
          if (rsp_valid[i] && rsp_ready[i]) begin
            rx_q[i].push_back('{rsp_data, rsp_resp, rsp_last});
            if (rsp_last) rlast_cyc = cyc;
          end
        if (len_err && !prev_lerr) lerr_cyc = cyc;
      end
      prev_arv   = m_axi_arvalid;
      prev_stall = m_axi_arvalid && !m_axi_arready;
      prev_addr  = m_axi_araddr;
      prev_len   = m_axi_arlen;
      prev_id    = m_axi_arid;
      prev_lerr  = len_err;
    end
  end

  task automatic wait_neg();
    @(negedge clk); #2;
  endtask

  task automatic clear_logs();
    for (int m = 0; m < NM; m++) begin
      exp_b[m].delete(); rx_q[m].delete();
    end
    ar_q.delete(); exp_ar.delete();
    ar_stall = 0; ar_unstable = 0; bad_valid = 0;
    acc_cyc = -1; arv_cyc = -1; rlast_cyc = -1; lerr_cyc = -1;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    for (int m = 0; m < NM; m++) req_q[m].delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    clear_logs();
    wait_neg();
  endtask

  task automatic push(input int m, input logic [AW-1:0] a, input logic [LW-1:0] l, input int beats);
    req_q[m].push_back('{a, l, beats});
    exp_b[m].push_back('{a, l, beats});
  endtask

  // Reference grant order: everything queued is pending at once, the next
  // grantee is the first pending master after the previous grantee.
  task automatic build_order(input int last);
    int pos[NM];
    int cur;
    bit found;
    cur = last;
    for (int m = 0; m < NM; m++) pos[m] = 0;
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      for (int k = 1; k <= NM; k++) begin
        int c;
        c = (cur + k) % NM;
        if (!found && pos[c] < exp_b[c].size()) begin
          exp_ar.push_back('{c, exp_b[c][pos[c]].addr, exp_b[c][pos[c]].len, 3'd3, 2'b01});
          pos[c]++;
          cur = c;
          found = 1'b1;
        end
      end
    end
  endtask

  function automatic int total_exp();
    int t = 0;
    for (int m = 0; m < NM; m++)
      for (int b = 0; b < exp_b[m].size(); b++) t += exp_b[m][b].beats;
    return t;
  endfunction

  function automatic int total_rx();
    int t = 0;
    for (int m = 0; m < NM; m++) t += rx_q[m].size();
    return t;
  endfunction

  // Number of beats for master m that differ from the expected stream.
  function automatic int beat_errs(input int m);
    int idx = 0, e = 0;
    for (int b = 0; b < exp_b[m].size(); b++)
      for (int k = 0; k < exp_b[m][b].beats; k++) begin
        if (idx >= rx_q[m].size()) e++;
        else if (rx_q[m][idx].data !== {2'b00, exp_b[m][b].addr, 32'(k)} ||
                 rx_q[m][idx].resp !== (2'(k) ^ exp_b[m][b].addr[3:2]) ||
                 rx_q[m][idx].last !== (k == exp_b[m][b].beats - 1)) e++;
        idx++;
      end
    if (idx != rx_q[m].size()) e++;
    return e;
  endfunction

  function automatic int ar_errs();
    int e = 0;
    if (ar_q.size() != exp_ar.size()) e++;
    for (int i = 0; i < ar_q.size() && i < exp_ar.size(); i++)
      if (ar_q[i].id != exp_ar[i].id || ar_q[i].addr !== exp_ar[i].addr || ar_q[i].len !== exp_ar[i].len ||
          ar_q[i].size !== exp_ar[i].size || ar_q[i].burst !== exp_ar[i].burst) e++;
    return e;
  endfunction

  task automatic wait_done(input string name);
    int c = 0;
    while (c < 5000 && total_rx() < total_exp()) begin wait_neg(); c++; end
    checks++;
    if (total_rx() < total_exp()) begin
      failures++;
      $display("FAIL %s_timeout: got %0d beats want %0d", name, total_rx(), total_exp());
    end
    repeat (3) wait_neg();
  endtask

  task automatic test_reset();
    @(posedge clk); #3 rst = 1'b1;
    wait_neg(); wait_neg();
    checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    checks++; if (rsp_valid !== '0) begin failures++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (m_axi_arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid: got %b want 0", m_axi_arvalid); end
    checks++; if (m_axi_rready !== 1'b0) begin failures++; $display("FAIL reset_rready: got %b want 0", m_axi_rready); end
    checks++; if (len_err !== 1'b0) begin failures++; $display("FAIL reset_len_err: got %b want 0", len_err); end
    checks++; if (stat_grant_cnt !== '0) begin failures++; $display("FAIL reset_stat: got %h want 0", stat_grant_cnt); end
    @(posedge clk); #3 rst = 1'b0;
    clear_logs();
    wait_neg();
  endtask

  task automatic test_single();
    slv_rand = 1'b1; rdy_rand = 1'b1; slv_ar_delay = 0; slv_extra = 0;
    push(2, 30'h100, 8'd3, 4);
    exp_ar.push_back('{2, 30'h100, 8'd3, 3'd3, 2'b01});
    wait_done("single");
    checks++; if (arv_cyc != acc_cyc + 1) begin failures++; $display("FAIL single_ar_latency: got %0d want %0d", arv_cyc - acc_cyc, 1); end
    checks++; if (ar_errs() !== 0) begin failures++; $display("FAIL single_ar_fields: got %0d errs want 0", ar_errs()); end
    for (int m = 0; m < NM; m++) begin
      checks++; if (beat_errs(m) !== 0) begin failures++; $display("FAIL single_beats_m%0d: got %0d errs want 0", m, beat_errs(m)); end
    end
    checks++; if (rx_q[2].size() != 4 || rx_q[2][3].last !== 1'b1) begin failures++; $display("FAIL single_last: got %0d beats want 4 with last on 4th", rx_q[2].size()); end
    checks++; if (bad_valid != 0) begin failures++; $display("FAIL single_rsp_valid_onehot: got %0d bad want 0", bad_valid); end
    checks++; if (len_err !== 1'b0) begin failures++; $display("FAIL single_len_err: got %b want 0", len_err); end
  endtask

  task automatic test_all_masters();
    do_reset();
    slv_rand = 1'b1; rdy_rand = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int m = 0; m < NM; m++) push(m, 30'(32'h1000 * (m + 1) + 32'h40 * r), 8'(m + r), m + r + 1);
    build_order(NM - 1);
    wait_done("all_masters");
    checks++; if (ar_errs() !== 0) begin failures++; $display("FAIL all_masters_order: got %0d errs want 0", ar_errs()); end
    for (int m = 0; m < NM; m++) begin
      checks++; if (beat_errs(m) !== 0) begin failures++; $display("FAIL all_masters_beats_m%0d: got %0d errs want 0", m, beat_errs(m)); end
    end
    checks++; if (bad_valid != 0) begin failures++; $display("FAIL all_masters_onehot: got %0d bad want 0", bad_valid); end
  endtask

  task automatic test_backpressure();
    int c = 0;
    clear_logs();
    slv_rand = 1'b0; rdy_rand = 1'b0; slv_ar_delay = 3;
    push(1, 30'h2000, 8'd7, 8);
    exp_ar.push_back('{1, 30'h2000, 8'd7, 3'd3, 2'b01});
    while (c < 200 && rx_q[1].size() < 3) begin wait_neg(); c++; end
    hold[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_neg();
      checks++;
      if (m_axi_rready !== 1'b0 || rsp_valid !== 4'b0010) begin
        failures++; $display("FAIL bp_stall_cyc%0d: got rready=%b rsp_valid=%b want 0/0010", i, m_axi_rready, rsp_valid);
      end
    end
    hold[1] = 1'b0;
    wait_done("backpressure");
    checks++; if (beat_errs(1) !== 0) begin failures++; $display("FAIL bp_beats: got %0d errs want 0", beat_errs(1)); end
    checks++; if (ar_stall != 3) begin failures++; $display("FAIL bp_ar_stall: got %0d want 3", ar_stall); end
    checks++; if (ar_unstable != 0) begin failures++; $display("FAIL bp_ar_stable: got %0d changes want 0", ar_unstable); end
    checks++; if (ar_errs() !== 0) begin failures++; $display("FAIL bp_ar_fields: got %0d errs want 0", ar_errs()); end
    slv_ar_delay = 0;
  endtask

  task automatic test_len_err();
    clear_logs();
    slv_extra = 1;
    push(0, 30'h300, 8'd1, 3);
    wait_done("len_err");
    slv_extra = 0;
    checks++; if (len_err !== 1'b1) begin failures++; $display("FAIL len_err_set: got %b want 1", len_err); end
    checks++; if (lerr_cyc != rlast_cyc + 1) begin failures++; $display("FAIL len_err_timing: got %0d want %0d", lerr_cyc - rlast_cyc, 1); end
    checks++; if (beat_errs(0) !== 0) begin failures++; $display("FAIL len_err_beats: got %0d errs want 0", beat_errs(0)); end
    clear_logs();
    push(3, 30'h340, 8'd2, 3);
    wait_done("len_err_sticky");
    checks++; if (len_err !== 1'b1) begin failures++; $display("FAIL len_err_sticky: got %b want 1", len_err); end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    clear_logs();
    slv_rand = 1'b0; rdy_rand = 1'b0;
    push(2, 30'h400, 8'd7, 8);
    while (c < 200 && rx_q[2].size() < 1) begin wait_neg(); c++; end
    rst = 1'b1;
    wait_neg();
    checks++; if (rsp_valid !== '0 || m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0) begin
      failures++; $display("FAIL mid_reset_valids: got rsp_valid=%b arvalid=%b rready=%b want 0", rsp_valid, m_axi_arvalid, m_axi_rready); end
    checks++; if (req_ready !== '0) begin failures++; $display("FAIL mid_reset_req_ready: got %b want 0", req_ready); end
    checks++; if (len_err !== 1'b0) begin failures++; $display("FAIL mid_reset_len_err: got %b want 0", len_err); end
    rst = 1'b0;
    clear_logs();
    push(0, 30'h500, 8'd2, 3);
    exp_ar.push_back('{0, 30'h500, 8'd2, 3'd3, 2'b01});
    wait_done("after_reset");
    checks++; if (ar_errs() !== 0) begin failures++; $display("FAIL after_reset_ar: got %0d errs want 0", ar_errs()); end
    checks++; if (beat_errs(0) !== 0) begin failures++; $display("FAIL after_reset_beats: got %0d errs want 0", beat_errs(0)); end
    checks++; if (len_err !== 1'b0) begin failures++; $display("FAIL after_reset_len_err: got %b want 0", len_err); end
  endtask

  task automatic test_stat();
    logic [31:0] exp_cnt [NM];
    do_reset();
    slv_rand = 1'b1; rdy_rand = 1'b1;
    for (int i = 0; i < 5; i++) push(0, 30'(32'h6000 + 32'h100 * i), 8'(i), i + 1);
    for (int i = 0; i < 2; i++) push(3, 30'(32'h7000 + 32'h100 * i), 8'd1, 2);
    build_order(NM - 1);
    wait_done("stat");
`ifdef AXI_RD_ARB_STAT_EN
    exp_cnt = '{32'd5, 32'd0, 32'd0, 32'd2};
`else
    exp_cnt = '{32'd0, 32'd0, 32'd0, 32'd0};
`endif
    for (int m = 0; m < NM; m++) begin
      checks++;
      if (stat_grant_cnt[m*32 +: 32] !== exp_cnt[m]) begin
        failures++; $display("FAIL stat_m%0d: got %0d want %0d", m, stat_grant_cnt[m*32 +: 32], exp_cnt[m]);
      end
    end
    checks++; if (ar_errs() !== 0) begin failures++; $display("FAIL stat_order: got %0d errs want 0", ar_errs()); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      do_reset();
      slv_rand = 1'b1; rdy_rand = 1'b1; slv_ar_delay = $urandom_range(0, 2);
      for (int m = 0; m < NM; m++) begin
        int nb;
        nb = $urandom_range(0, 3);
        for (int b = 0; b < nb; b++) begin
          logic [LW-1:0] l;
          l = LW'($urandom_range(0, 7));
          push(m, 30'($urandom), l, int'(l) + 1);
        end
      end
      build_order(NM - 1);
      wait_done("random");
      checks++; if (ar_errs() !== 0) begin failures++; $display("FAIL random%0d_order: got %0d errs want 0", r, ar_errs()); end
      for (int m = 0; m < NM; m++) begin
        checks++; if (beat_errs(m) !== 0) begin failures++; $display("FAIL random%0d_beats_m%0d: got %0d errs want 0", r, m, beat_errs(m)); end
      end
      checks++; if (bad_valid != 0) begin failures++; $display("FAIL random%0d_onehot: got %0d bad want 0", r, bad_valid); end
      checks++; if (len_err !== 1'b0) begin failures++; $display("FAIL random%0d_len_err: got %b want 0", r, len_err); end
    end
    slv_ar_delay = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_all_masters();
    test_backpressure();
    test_len_err();
    test_reset_mid();
    test_stat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
